// File: rtl/nd_1ton.sv
// rtl/nd_1ton.sv - 1-to-N comparator routing node with four-phase handshakes
// Optional per-output delivery counters: define NS_ND_1TON_STATS_EN.
`timescale 1ns/1ps
module nd_1ton #(
    parameter int ASZ = 6,
    parameter int DSZ = 4,
    parameter int NUM_OUT = 4,
    parameter logic [(NUM_OUT-1)*ASZ-1:0] REF_VALS = {6'd40, 6'd23, 6'd10},
    parameter int OPER = 0
) (
    input  logic                           i_clk,
    input  logic                           reset,
    output logic                           ready,
    input  logic                           rcv0_req,
    input  logic [ASZ+DSZ-1:0]             rcv0_data,
    output logic                           rcv0_ack,
    output logic [NUM_OUT-1:0]             snd_req,
    output logic [NUM_OUT*(ASZ+DSZ)-1:0]   snd_data,
    input  logic [NUM_OUT-1:0]             snd_ack
`ifdef NS_ND_1TON_STATS_EN
    ,
    output logic [NUM_OUT*8-1:0]           o_cnt
`endif
);

    localparam int MSZ = ASZ + DSZ;
    localparam int IW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic {R_IDLE, R_ACK} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_t;

    logic [1:0]               rdy_q, rdy_d;
    logic [1:0]               req_sync_q, req_sync_d;
    logic [NUM_OUT-1:0]       ack_meta_q, ack_meta_d;
    logic [NUM_OUT-1:0]       ack_s_q, ack_s_d;
    rx_state_t                rx_q, rx_d;
    logic                     ack_q, ack_d;
    tx_state_t                tx_q [NUM_OUT];
    tx_state_t                tx_d [NUM_OUT];
    logic [NUM_OUT-1:0][MSZ-1:0] mbuf_q, mbuf_d;

    logic [ASZ-1:0]           addr;
    logic [IW-1:0]            route;
    logic [NUM_OUT-1:0]       load;

    assign addr = rcv0_data[MSZ-1:DSZ];

    // Route index = how many thresholds the address passes; works for unsorted thresholds too
    always_comb begin
        route = '0;
        for (int i = 0; i < NUM_OUT-1; i++) begin
            if ((OPER != 0) ? (addr >= REF_VALS[i*ASZ +: ASZ])
                            : (addr >  REF_VALS[i*ASZ +: ASZ]))
                route = route + IW'(1);
        end
    end

    // Synchroniser and ready shift paths
    always_comb begin
        rdy_d      = {rdy_q[0], 1'b1};
        req_sync_d = {req_sync_q[0], rcv0_req};
        ack_meta_d = snd_ack;
        ack_s_d    = ack_meta_q;
    end

    // Receive FSM: accept only when the target buffer's registered TX state is idle
    always_comb begin
        rx_d  = rx_q;
        ack_d = ack_q;
        load  = '0;
        case (rx_q)
            R_IDLE: begin
                if (rdy_q[1] && req_sync_q[1] && (tx_q[route] == T_IDLE)) begin
                    rx_d        = R_ACK;
                    ack_d       = 1'b1;
                    load[route] = 1'b1;
                end
            end
            R_ACK: begin
                if (!req_sync_q[1]) begin
                    rx_d  = R_IDLE;
                    ack_d = 1'b0;
                end
            end
            default: begin
                rx_d  = R_IDLE;
                ack_d = 1'b0;
            end
        endcase
    end

    // Per-output send FSMs; the buffer keeps its message until the next load
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            tx_d[k]   = tx_q[k];
            mbuf_d[k] = mbuf_q[k];
            case (tx_q[k])
                T_IDLE: begin
                    if (load[k]) begin
                        tx_d[k]   = T_REQ;
                        mbuf_d[k] = rcv0_data;
                    end
                end
                T_REQ:   if (ack_s_q[k])  tx_d[k] = T_REL;
                T_REL:   if (!ack_s_q[k]) tx_d[k] = T_IDLE;
                default: tx_d[k] = T_IDLE;
            endcase
        end
    end

    // State registers; reset discards any in-flight message
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            rdy_q      <= '0;
            req_sync_q <= '0;
            ack_meta_q <= '0;
            ack_s_q    <= '0;
            rx_q       <= R_IDLE;
            ack_q      <= 1'b0;
            mbuf_q     <= '0;
            for (int k = 0; k < NUM_OUT; k++) tx_q[k] <= T_IDLE;
        end else begin
            rdy_q      <= rdy_d;
            req_sync_q <= req_sync_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            rx_q       <= rx_d;
            ack_q      <= ack_d;
            mbuf_q     <= mbuf_d;
            for (int k = 0; k < NUM_OUT; k++) tx_q[k] <= tx_d[k];
        end
    end

    // Output decode
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) snd_req[k] = (tx_q[k] == T_REQ);
    end

    assign snd_data = mbuf_q;
    assign rcv0_ack = ack_q;
    assign ready    = rdy_q[1];

`ifdef NS_ND_1TON_STATS_EN
    logic [NUM_OUT-1:0][7:0] cnt_q, cnt_d;

    // Count each acknowledged delivery (T_REQ -> T_REL), wrapping at 8 bits
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++)
            cnt_d[k] = cnt_q[k] + (((tx_q[k] == T_REQ) && ack_s_q[k]) ? 8'd1 : 8'd0);
    end

    // Counter registers
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_nd_1ton.sv
// tb/tb_nd_1ton.sv - directed self-checking bench for nd_1ton
`timescale 1ns/1ps
module tb_nd_1ton;

    logic        clk;
    logic        rst_n;
    logic        rdy, req, ack;
    logic [9:0]  dat;
    logic [3:0]  sreq, sack;
    logic [39:0] sdat;
    logic        ge_rdy, ge_req, ge_ack;
    logic [9:0]  ge_dat;
    logic [3:0]  ge_sreq, ge_sack;
    logic [39:0] ge_sdat;
`ifdef NS_ND_1TON_STATS_EN
    logic [31:0] cnt, ge_cnt;
`endif

    int errors = 0;
    int checks = 0;

    nd_1ton u_gt (
        .i_clk(clk), .reset(rst_n), .ready(rdy),
        .rcv0_req(req), .rcv0_data(dat), .rcv0_ack(ack),
        .snd_req(sreq), .snd_data(sdat), .snd_ack(sack)
`ifdef NS_ND_1TON_STATS_EN
        , .o_cnt(cnt)
`endif
    );

    nd_1ton #(.OPER(1)) u_ge (
        .i_clk(clk), .reset(rst_n), .ready(ge_rdy),
        .rcv0_req(ge_req), .rcv0_data(ge_dat), .rcv0_ack(ge_ack),
        .snd_req(ge_sreq), .snd_data(ge_sdat), .snd_ack(ge_sack)
`ifdef NS_ND_1TON_STATS_EN
        , .o_cnt(ge_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_put(input bit g, input logic [9:0] m, output int lat);
        if (g) begin ge_dat = m; ge_req = 1'b1; end
        else   begin dat = m;    req = 1'b1;    end
        lat = 0;
        do begin @(negedge clk); lat++; end
        while (((g ? ge_ack : ack) == 1'b0) && lat < 100);
    endtask

    task automatic rx_drop(input bit g);
        int n = 0;
        if (g) ge_req = 1'b0; else req = 1'b0;
        do begin @(negedge clk); n++; end
        while ((g ? ge_ack : ack) && n < 100);
        chk("rx_ack_fall", 64'(n), 64'd3);
    endtask

    task automatic tx_done(input bit g, input int k);
        int n = 0;
        if (g) ge_sack[k] = 1'b1; else sack[k] = 1'b1;
        do begin @(negedge clk); n++; end
        while ((g ? ge_sreq[k] : sreq[k]) && n < 100);
        chk("tx_req_fall", 64'(n), 64'd3);
        if (g) ge_sack[k] = 1'b0; else sack[k] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_edge1", 64'(rdy), 64'd0);
        @(posedge clk); #1;
        chk("ready_edge2", 64'(rdy), 64'd1);
        @(negedge clk);
    endtask

    logic [5:0]  r_addr [8] = '{6'd5, 6'd10, 6'd11, 6'd23, 6'd24, 6'd40, 6'd41, 6'd55};
    int          r_out  [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    logic [5:0]  g_addr [4] = '{6'd10, 6'd23, 6'd40, 6'd9};
    int          g_out  [4] = '{1, 2, 3, 0};
    logic [9:0]  msg;
    int          lat;
    int          n;

    initial begin
        rst_n = 1'b0;
        req = 1'b0; dat = '0; sack = '0;
        ge_req = 1'b0; ge_dat = '0; ge_sack = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(rdy), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_sreq", 64'(sreq), 64'd0);
        chk("rst_sdat", 64'(sdat), 64'd0);
        release_reset();

        // GT routing across every threshold boundary
        for (int i = 0; i < 8; i++) begin
            msg = {r_addr[i], 4'(i + 3)};
            rx_put(0, msg, lat);
            chk("route_ack_lat", 64'(lat), 64'd3);
            chk("route_sreq", 64'(sreq), 64'(4'b0001 << r_out[i]));
            chk("route_data", 64'(sdat[r_out[i]*10 +: 10]), 64'(msg));
            rx_drop(0);
            tx_done(0, r_out[i]);
        end
        chk("data_held", 64'(sdat[39:30]), 64'({6'd55, 4'd10}));

        // GE routing
        for (int i = 0; i < 4; i++) begin
            msg = {g_addr[i], 4'hC};
            rx_put(1, msg, lat);
            chk("ge_sreq", 64'(ge_sreq), 64'(4'b0001 << g_out[i]));
            chk("ge_data", 64'(ge_sdat[g_out[i]*10 +: 10]), 64'(msg));
            rx_drop(1);
            tx_done(1, g_out[i]);
        end

        // Backpressure on output 2 blocks the following messages in order
        rx_put(0, {6'd30, 4'h1}, lat);
        rx_drop(0);
        chk("bp_req2", 64'(sreq), 64'(4'b0100));
        dat = {6'd31, 4'h2};
        req = 1'b1;
        repeat (20) @(negedge clk);
        chk("bp_hold_ack", 64'(ack), 64'd0);
        chk("bp_out0_idle", 64'(sreq[0]), 64'd0);
        chk("bp_old_data", 64'(sdat[29:20]), 64'({6'd30, 4'h1}));
        tx_done(0, 2);
        n = 0;
        while (!ack && n < 100) begin @(negedge clk); n++; end
        chk("bp_31_acc", 64'(ack), 64'd1);
        chk("bp_31_data", 64'(sdat[29:20]), 64'({6'd31, 4'h2}));
        chk("bp_31_only", 64'(sreq), 64'(4'b0100));
        rx_drop(0);
        rx_put(0, {6'd5, 4'h3}, lat);
        chk("bp_5_lat", 64'(lat), 64'd3);
        chk("bp_5_sreq", 64'(sreq), 64'(4'b0101));
        chk("bp_5_data", 64'(sdat[9:0]), 64'({6'd5, 4'h3}));
        rx_drop(0);
        tx_done(0, 2);
        tx_done(0, 0);

        // Two outputs in flight concurrently
        rx_put(0, {6'd5, 4'h4}, lat);
        rx_drop(0);
        rx_put(0, {6'd50, 4'h5}, lat);
        rx_drop(0);
        repeat (20) @(negedge clk);
        chk("conc_both", 64'(sreq), 64'(4'b1001));
        sack = 4'b1001;
        n = 0;
        do begin @(negedge clk); n++; end while (sreq != 4'b0000 && n < 100);
        chk("conc_fall_lat", 64'(n), 64'd3);
        sack = 4'b0000;
        repeat (3) @(negedge clk);
        chk("conc_idle", 64'(sreq), 64'd0);

        // Asynchronous reset mid-handshake
        rx_put(0, {6'd15, 4'h6}, lat);
        chk("mid_sreq1", 64'(sreq), 64'(4'b0010));
        chk("mid_ack", 64'(ack), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ack", 64'(ack), 64'd0);
        chk("arst_sreq", 64'(sreq), 64'd0);
        chk("arst_sdat", 64'(sdat), 64'd0);
        chk("arst_ready", 64'(rdy), 64'd0);
        req = 1'b0;
        release_reset();
        rx_put(0, {6'd41, 4'h7}, lat);
        chk("post_rst_lat", 64'(lat), 64'd3);
        chk("post_rst_sreq", 64'(sreq), 64'(4'b1000));
        chk("post_rst_data", 64'(sdat[39:30]), 64'({6'd41, 4'h7}));
        rx_drop(0);
        tx_done(0, 3);

`ifdef NS_ND_1TON_STATS_EN
        // Delivery counter wraps after 256 messages
        @(negedge clk);
        #2 rst_n = 1'b0;
        release_reset();
        for (int i = 0; i < 257; i++) begin
            rx_put(0, {6'd2, 4'h0}, lat);
            rx_drop(0);
            tx_done(0, 0);
        end
        chk("cnt_out0_wrap", 64'(cnt[7:0]), 64'd1);
        chk("cnt_others", 64'(cnt[31:8]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
